// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NOC router constants and flit type
package noc_pkg;

  localparam int DEF_FLIT_W = 32;
  localparam int NUM_PORTS  = 5;

  localparam int N_IDX = 4;
  localparam int S_IDX = 3;
  localparam int E_IDX = 2;
  localparam int W_IDX = 1;
  localparam int L_IDX = 0;

  typedef logic [DEF_FLIT_W-1:0] flit_t;

endpackage

// File: rtl/noc_fifo.sv
// rtl/noc_fifo.sv - DEPTH x WIDTH flit FIFO with occupancy count, shared with the input buffers
module noc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/noc_output_port.sv
// rtl/noc_output_port.sv - per-direction output stage: grant, input mux, output FIFO, link counter
module noc_output_port
  import noc_pkg::*;
#(
  parameter int FLIT_W  = DEF_FLIT_W,
  parameter int DEPTH   = 4,
  parameter int PORT_ID = N_IDX
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        turn_i,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS*FLIT_W-1:0] flit_i,
  output logic [NUM_PORTS-1:0]        grant_o,
  output logic                        out_valid_o,
  output logic [FLIT_W-1:0]           out_flit_o,
  input  logic                        out_ready_i,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic [15:0]                 fwd_cnt_o
);

  logic [NUM_PORTS-1:0] w_self_mask;
  logic                 w_turn_onehot;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [FLIT_W-1:0]    w_push_flit;
  logic [15:0]          r_fwd_cnt;

  assign w_self_mask   = NUM_PORTS'(1) << PORT_ID;
  assign w_turn_onehot = (turn_i != '0) && ((turn_i & (turn_i - NUM_PORTS'(1))) == '0);

  // Full is the registered occupancy, so a same-cycle pop never frees a slot for a push.
  assign grant_o = (rst && w_turn_onehot && !w_full) ? (turn_i & req_i & ~w_self_mask) : '0;
  assign w_push  = |grant_o;
  assign w_pop   = out_valid_o && out_ready_i;

  always_comb begin
    w_push_flit = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_push_flit = w_push_flit | (flit_i[k*FLIT_W +: FLIT_W] & {FLIT_W{grant_o[k]}});
    end
  end

  noc_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (w_push),
    .i_data  (w_push_flit),
    .i_pop   (w_pop),
    .o_data  (out_flit_o),
    .o_count (count_o),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid_o = !w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_fwd_cnt <= '0;
    else if (w_pop) r_fwd_cnt <= r_fwd_cnt + 16'd1;
  end

  assign fwd_cnt_o = r_fwd_cnt;

endmodule

// File: tb/tb_noc_output_port.sv
// tb/tb_noc_output_port.sv - directed self-checking bench for noc_output_port (PORT_ID=N, DEPTH=4)
module tb_noc_output_port;
  import noc_pkg::*;

  localparam int FLIT_W = DEF_FLIT_W;
  localparam int DEPTH  = 4;

  logic                        clk;
  logic                        rst;
  logic [NUM_PORTS-1:0]        turn_i;
  logic [NUM_PORTS-1:0]        req_i;
  logic [NUM_PORTS*FLIT_W-1:0] flit_i;
  logic [NUM_PORTS-1:0]        grant_o;
  logic                        out_valid_o;
  logic [FLIT_W-1:0]           out_flit_o;
  logic                        out_ready_i;
  logic [$clog2(DEPTH):0]      count_o;
  logic [15:0]                 fwd_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  noc_output_port #(
    .FLIT_W  (FLIT_W),
    .DEPTH   (DEPTH),
    .PORT_ID (N_IDX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .turn_i      (turn_i),
    .req_i       (req_i),
    .flit_i      (flit_i),
    .grant_o     (grant_o),
    .out_valid_o (out_valid_o),
    .out_flit_o  (out_flit_o),
    .out_ready_i (out_ready_i),
    .count_o     (count_o),
    .fwd_cnt_o   (fwd_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flits(input logic [31:0] base);
    for (int k = 0; k < NUM_PORTS; k++) flit_i[k*FLIT_W +: FLIT_W] = base + 32'(k);
  endtask

  initial begin
    rst         = 1'b0;
    turn_i      = 5'b00001;
    req_i       = 5'b11111;
    flit_i      = '0;
    out_ready_i = 1'b0;

    // 1 reset
    @(negedge clk);
    check_eq("rst_grant", 32'(grant_o), 32'h0);
    check_eq("rst_valid", 32'(out_valid_o), 32'h0);
    check_eq("rst_count", 32'(count_o), 32'h0);
    check_eq("rst_fwd", 32'(fwd_cnt_o), 32'h0);
    check_eq("rst_flit", out_flit_o, 32'h0);
    next_cycle();
    rst = 1'b1;
    turn_i = '0;
    req_i = '0;

    // 2 single flit from S
    turn_i = 5'b01000; req_i = 5'b01000; out_ready_i = 1'b1;
    flit_i[S_IDX*FLIT_W +: FLIT_W] = 32'hA5A5_0001;
    @(negedge clk);
    check_eq("single_grant", 32'(grant_o), 32'h08);
    next_cycle();
    turn_i = '0; req_i = '0;
    @(negedge clk);
    check_eq("single_valid", 32'(out_valid_o), 32'h1);
    check_eq("single_flit", out_flit_o, 32'hA5A5_0001);
    next_cycle();
    @(negedge clk);
    check_eq("single_fwd", 32'(fwd_cnt_o), 32'h1);
    check_eq("single_empty", 32'(out_valid_o), 32'h0);

    // 3 full / backpressure from E
    next_cycle();
    out_ready_i = 1'b0; turn_i = 5'b00100; req_i = 5'b00100;
    for (int i = 0; i < 4; i++) begin
      flit_i[E_IDX*FLIT_W +: FLIT_W] = 32'h1000_0000 + 32'(i);
      @(negedge clk);
      check_eq("fill_grant", 32'(grant_o), 32'h04);
      next_cycle();
    end
    flit_i[E_IDX*FLIT_W +: FLIT_W] = 32'h1000_0004;
    @(negedge clk);
    check_eq("full_count", 32'(count_o), 32'h4);
    check_eq("full_grant", 32'(grant_o), 32'h0);
    next_cycle();
    out_ready_i = 1'b1;
    @(negedge clk);
    check_eq("full_pop_nogrant", 32'(grant_o), 32'h0);
    check_eq("full_head0", out_flit_o, 32'h1000_0000);
    next_cycle();
    out_ready_i = 1'b0;
    @(negedge clk);
    check_eq("retry_count", 32'(count_o), 32'h3);
    check_eq("retry_grant", 32'(grant_o), 32'h04);
    next_cycle();
    turn_i = '0; req_i = '0; out_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check_eq("drain_valid", 32'(out_valid_o), 32'h1);
      check_eq("drain_flit", out_flit_o, 32'h1000_0000 + 32'(i));
      next_cycle();
    end
    @(negedge clk);
    check_eq("drain_count", 32'(count_o), 32'h0);
    check_eq("drain_fwd", 32'(fwd_cnt_o), 32'd6);

    // 4 illegal turns
    req_i = 5'b11111;
    set_flits(32'hB000_0000);
    begin
      logic [4:0] bad_turns [3];
      bad_turns[0] = 5'b00000;
      bad_turns[1] = 5'b10100;
      bad_turns[2] = 5'b10000;
      for (int i = 0; i < 3; i++) begin
        next_cycle();
        turn_i = bad_turns[i];
        @(negedge clk);
        check_eq("illegal_grant", 32'(grant_o), 32'h0);
      end
    end
    next_cycle();
    turn_i = '0;
    @(negedge clk);
    check_eq("illegal_count", 32'(count_o), 32'h0);

    // 5 rotation S,E,W,L with streaming link
    set_flits(32'hC000_0000);
    begin
      logic [4:0] rot [4];
      rot[0] = 5'b01000; rot[1] = 5'b00100; rot[2] = 5'b00010; rot[3] = 5'b00001;
      for (int i = 0; i < 5; i++) begin
        next_cycle();
        turn_i = (i < 4) ? rot[i] : 5'b00000;
        @(negedge clk);
        if (i < 4) check_eq("rot_grant", 32'(grant_o), 32'(rot[i]));
        if (i > 0) begin
          check_eq("rot_flit", out_flit_o, 32'hC000_0000 + 32'(4 - i));
          check_eq("rot_count", 32'(count_o), 32'h1);
        end
      end
    end
    next_cycle();
    @(negedge clk);
    check_eq("rot_empty", 32'(out_valid_o), 32'h0);
    check_eq("rot_fwd", 32'(fwd_cnt_o), 32'd10);

    // 6 counter wrap, then reset with a partly filled FIFO
    next_cycle();
    turn_i = 5'b01000; req_i = 5'b01000;
    for (int i = 0; i < 65525; i++) next_cycle();
    turn_i = '0;
    next_cycle();
    @(negedge clk);
    check_eq("wrap_ffff", 32'(fwd_cnt_o), 32'hFFFF);
    next_cycle();
    turn_i = 5'b01000;
    next_cycle();
    turn_i = '0;
    next_cycle();
    @(negedge clk);
    check_eq("wrap_zero", 32'(fwd_cnt_o), 32'h0);

    next_cycle();
    out_ready_i = 1'b0; turn_i = 5'b00010; req_i = 5'b00010;
    for (int i = 0; i < 3; i++) next_cycle();
    @(negedge clk);
    check_eq("pre_rst_count", 32'(count_o), 32'h3);
    rst = 1'b0;
    #1;
    check_eq("async_rst_count", 32'(count_o), 32'h0);
    check_eq("async_rst_valid", 32'(out_valid_o), 32'h0);
    check_eq("async_rst_grant", 32'(grant_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
